// File: rtl/mobilenet_mul_arb_pkg.sv
// Shared types and widths for the MobileNet shared-multiplier arbiter.
//   A_W / B_W / P_W : multiplicand, multiplier and product widths (signed 16x8 -> 24)
//   MUL_LAT_DEF     : default number of register stages in the shared multiplier
//   ID_MAX_W        : widest requester id the tag struct can carry (up to 8 requesters)
//   tag_t           : per-stage in-flight tag {vld, id}
package mobilenet_mul_arb_pkg;

  localparam int A_W         = 16;
  localparam int B_W         = 8;
  localparam int P_W         = 24;
  localparam int MUL_LAT_DEF = 3;
  localparam int ID_MAX_W    = 3;

  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mobilenet_rr_arbiter.sv
// Round-robin arbiter: searches i_req starting at i_ptr, upward with wrap, and
// returns the first requester found as a one-hot grant plus its binary index.
// Pointer update is left to the instantiating controller so the same block can
// be reused by any shared-datapath controller.
//   i_req   [N-1:0]  request vector
//   i_ptr   [IW-1:0] highest-priority index this cycle (must be < N)
//   o_grant [N-1:0]  one-hot grant (all zero when no request)
//   o_idx   [IW-1:0] index of granted requester (0 when none)
//   o_any            some requester granted
module mobilenet_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Candidate index for each priority slot: slot 0 is the pointer itself.
  logic [IW-1:0] w_cand [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign w_cand[gi] = IW'((int'(i_ptr) + gi) % N);
    end
  endgenerate

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[w_cand[k]]) begin
        o_any             = 1'b1;
        o_idx             = w_cand[k];
        o_grant[w_cand[k]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mobilenet_mul_share_arb.sv
// Shares one external pipelined signed 16x8->24 multiplier between NUM_REQ
// requesters. Round-robin issue, a tag pipeline that mirrors the multiplier
// stages to track in-flight ops, and one response port whose backpressure
// freezes the multiplier through mul_ce.
// Optional feature macro: MOBILENET_MUL_ARB_STATS_EN enables the saturating
// issue counter on stat_issue_cnt; without it the port is tied to 0.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready = accepted this cycle)
//   req_a/req_b           packed signed operands, requester i at [16i+:16]/[8i+:8]
//   mul_ce                clock enable of the shared multiplier
//   mul_din0/mul_din1     operands to the multiplier (0 when nothing granted)
//   mul_dout              product from the multiplier
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_id       product and the requester that issued it
//   stat_issue_cnt        issued-op count (see macro above)
module mobilenet_mul_share_arb
  import mobilenet_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
  input  logic [P_W-1:0]         mul_dout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [P_W-1:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            stat_issue_cnt
);

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_grant_any;
  logic               w_issue;
  logic [ID_W-1:0]    r_rr_ptr;
  tag_t               r_tag [MUL_LAT];

  mobilenet_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_grant_any)
  );

  // The last tag stage lines up with the multiplier output register.
  assign rsp_valid = r_tag[MUL_LAT-1].vld;
  assign rsp_id    = r_tag[MUL_LAT-1].id[ID_W-1:0];
  assign rsp_data  = mul_dout;

  // A held, unaccepted response freezes the whole pipeline, so nothing can be
  // overwritten; an accepted one frees its slot in the same cycle.
  assign mul_ce    = !rsp_valid || rsp_ready;
  assign req_ready = w_grant & {NUM_REQ{mul_ce}};
  assign w_issue   = w_grant_any && mul_ce;

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (w_grant_any) begin
      mul_din0 = req_a[w_grant_idx*A_W +: A_W];
      mul_din1 = req_b[w_grant_idx*B_W +: B_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    end
  end

  // Tag pipe advances on exactly the same enable as the multiplier; a cycle
  // without an issue pushes a bubble so stale multiplier data stays masked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < MUL_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else if (mul_ce) begin
      r_tag[0].vld <= w_issue;
      r_tag[0].id  <= ID_MAX_W'(w_grant_idx);
      for (int s = 1; s < MUL_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

`ifdef MOBILENET_MUL_ARB_STATS_EN
  logic [31:0] r_stat_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_cnt <= '0;
    end else if (w_issue && (r_stat_cnt != 32'hFFFF_FFFF)) begin
      r_stat_cnt <= r_stat_cnt + 32'd1;
    end
  end

  assign stat_issue_cnt = r_stat_cnt;
`else
  assign stat_issue_cnt = '0;
`endif

endmodule

// File: tb/tb_mobilenet_mul_share_arb.sv
// Self-checking bench for mobilenet_mul_share_arb (NUM_REQ=4, MUL_LAT=3).
// Contains a ce-gated pipelined multiplier model as the environment, and a
// queue-based reference: each issued op carries the number of enabled edges it
// has seen and becomes the visible response once it has seen MUL_LAT of them.
module tb_mobilenet_mul_share_arb;
  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 3;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*16-1:0] req_a = '0;
  logic [NUM_REQ*8-1:0] req_b = '0;
  logic                 mul_ce;
  logic [15:0]          mul_din0;
  logic [7:0]           mul_din1;
  logic [23:0]          mul_dout;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [23:0]          rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic [31:0]          stat_issue_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mobilenet_mul_share_arb #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .stat_issue_cnt(stat_issue_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] smul(input logic [15:0] a, input logic [7:0] b);
    logic signed [23:0] ea, eb;
    ea = {{8{a[15]}}, a};
    eb = {{16{b[7]}}, b};
    return ea * eb;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Environment: shared multiplier, MUL_LAT ce-gated stages, no reset.
  logic [23:0] mp [MUL_LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      mp[0] <= smul(mul_din0, mul_din1);
      for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
    end
  end
  assign mul_dout = mp[MUL_LAT-1];

  // Reference model state.
  typedef struct {
    int          id;
    logic [23:0] prod;
    int          cnt;
  } op_t;
  op_t         q[$];
  int          m_ptr = 0;
  logic [31:0] m_stat = '0;
  logic [NUM_REQ-1:0] m_acc = '0;

  logic        e_rv, e_ce;
  int          e_g;
  logic [NUM_REQ-1:0] e_rdy;
  logic [15:0] e_a;
  logic [7:0]  e_b;

  // Compare process: inputs only change at posedge+1, so values seen here are
  // the ones the next edge will act on.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_ptr  = 0;
      m_stat = '0;
    end
    e_rv = (q.size() > 0) && (q[0].cnt == MUL_LAT);
    e_ce = !e_rv || rsp_ready;
    e_g  = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (e_g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) e_g = (m_ptr + k) % NUM_REQ;
    end
    e_rdy = '0;
    e_a   = '0;
    e_b   = '0;
    if (e_g >= 0) begin
      e_a = req_a[16*e_g +: 16];
      e_b = req_b[8*e_g +: 8];
      if (e_ce) e_rdy[e_g] = 1'b1;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("mul_ce", 32'(mul_ce), 32'(e_ce));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    chk("mul_din0", 32'(mul_din0), 32'(e_a));
    chk("mul_din1", 32'(mul_din1), 32'(e_b));
    if (e_rv) begin
      chk("rsp_data", 32'(rsp_data), 32'(q[0].prod));
      chk("rsp_id", 32'(rsp_id), q[0].id);
    end else if (reset) begin
      chk("rsp_id_rst", 32'(rsp_id), 32'd0);
    end
`ifdef MOBILENET_MUL_ARB_STATS_EN
    chk("stat_cnt", stat_issue_cnt, m_stat);
`else
    chk("stat_cnt", stat_issue_cnt, 32'd0);
`endif
    m_acc = reset ? '0 : e_rdy;
    if (!reset && e_ce) begin
      if (e_rv && rsp_ready) void'(q.pop_front());
      foreach (q[j]) q[j].cnt = q[j].cnt + 1;
      if (e_g >= 0) begin
        q.push_back('{id: e_g, prod: smul(e_a, e_b), cnt: 1});
        m_ptr = (e_g + 1) % NUM_REQ;
        if (m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 32'd1;
      end
    end
  end

  // Stimulus helpers.
  logic [23:0]        hs_data[$];
  int                 hs_id[$];
  logic [NUM_REQ-1:0] gnt_log[$];

  task automatic set_req(input int i, input logic [15:0] a, input logic [7:0] b);
    req_valid[i]      = 1'b1;
    req_a[16*i +: 16] = a;
    req_b[8*i +: 8]   = b;
  endtask

  task automatic step();
    #1;
    if (rsp_valid && rsp_ready) begin
      hs_data.push_back(rsp_data);
      hs_id.push_back(int'(rsp_id));
    end
    gnt_log.push_back(req_ready);
    @(posedge clk);
    #1;
    req_valid = req_valid & ~m_acc;
  endtask

  task automatic clear_logs();
    hs_data.delete();
    hs_id.delete();
    gnt_log.delete();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    clear_logs();
  endtask

  logic [15:0] t3a [6] = '{16'h0001, 16'h0002, 16'hFFFB, 16'd1000, 16'hFFFF, 16'd300};
  logic [7:0]  t3b [6] = '{8'h01, 8'hFD, 8'h07, 8'h64, 8'hFF, 8'h80};
  logic [23:0] t3p [6] = '{24'h000001, 24'hFFFFFA, 24'hFFFFDD, 24'h0186A0, 24'h000001, 24'hFF6A00};

  initial begin
    int sent;

    // Reset state and a single op from requester 0: 3 * -2.
    do_reset();
    chk("t1_rst_valid", 32'(rsp_valid), 32'd0);
    set_req(0, 16'd3, 8'hFE);
    #1 chk("t1_ready", 32'(req_ready), 32'b0001);
    @(posedge clk); #1 req_valid = '0;
    chk("t1_lat0", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 chk("t1_lat1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 chk("t1_lat2", 32'(rsp_valid), 32'd1);
    chk("t1_data", 32'(rsp_data), 32'h00FFFFFA);
    chk("t1_id", 32'(rsp_id), 32'd0);
    @(posedge clk); #1;

    // All four requesters held busy: strict rotation, one grant per cycle.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i]) set_req(i, 16'($urandom), 8'($urandom));
      end
      step();
    end
    req_valid = '0;
    chk("t2_nrsp", 32'(hs_id.size() >= 8), 32'd1);
    for (int k = 0; k < 8; k++) begin
      chk("t2_grant", 32'(gnt_log[k]), 32'(1 << (k % 4)));
      chk("t2_rsp_id", hs_id[k], k % 4);
    end

    // Six-op stream with a three-cycle response stall in the middle.
    do_reset();
    sent = 0;
    for (int c = 0; c < 24; c++) begin
      rsp_ready = !(c >= 4 && c <= 6);
      if (req_valid == '0 && sent < 6) begin
        set_req(sent % NUM_REQ, t3a[sent], t3b[sent]);
        sent++;
      end
      if (c >= 4 && c <= 6) begin
        #1;
        chk("t3_ce_stall", 32'(mul_ce), 32'd0);
        chk("t3_ready_stall", 32'(req_ready), 32'd0);
      end
      step();
    end
    rsp_ready = 1'b1;
    chk("t3_count", hs_data.size(), 6);
    for (int k = 0; k < 6; k++) chk("t3_data", 32'(hs_data[k]), 32'(t3p[k]));

    // Operand extremes.
    do_reset();
    set_req(1, 16'h8000, 8'h80);
    set_req(3, 16'h7FFF, 8'h80);
    repeat (8) step();
    chk("t4_count", hs_data.size(), 2);
    chk("t4_min_min", 32'(hs_data[0]), 32'h00400000);
    chk("t4_max_min", 32'(hs_data[1]), 32'h00C00080);
    chk("t4_id0", hs_id[0], 1);
    chk("t4_id1", hs_id[1], 3);

    // Reset with two ops in flight.
    do_reset();
    set_req(0, 16'd11, 8'd5);
    set_req(1, 16'd12, 8'd6);
    step();
    step();
    step();
    chk("t5_pre_valid", 32'(rsp_valid), 32'd1);
    reset     = 1'b1;
    req_valid = '0;
    #1;
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_id", 32'(rsp_id), 32'd0);
    step();
    step();
    reset = 1'b0;
    clear_logs();
    set_req(0, 16'd7, 8'd7);
    set_req(2, 16'd9, 8'd9);
    #1 chk("t5_first_grant", 32'(req_ready), 32'b0001);
    repeat (8) step();
    chk("t5_count", hs_data.size(), 2);
    chk("t5_data0", 32'(hs_data[0]), 32'd49);
    chk("t5_data1", 32'(hs_data[1]), 32'd81);

    // Issue counter after exactly ten issues.
    do_reset();
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      if (req_valid == '0 && sent < 10) begin
        set_req(c % NUM_REQ, 16'($urandom), 8'($urandom));
        sent++;
      end
      step();
    end
`ifdef MOBILENET_MUL_ARB_STATS_EN
    chk("t6_stat", stat_issue_cnt, 32'd10);
`else
    chk("t6_stat", stat_issue_cnt, 32'd0);
`endif

    // Randomized traffic, random backpressure, occasional reset pulses.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0:       set_req(i, 16'h8000, 8'($urandom));
            1:       set_req(i, 16'($urandom), 8'h80);
            default: set_req(i, 16'($urandom), 8'($urandom));
          endcase
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        reset     = 1'b1;
        req_valid = '0;
      end else begin
        reset = 1'b0;
      end
      step();
    end
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
